// File: rtl/l2_cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : l2_types_pkg
//  Purpose  : Shared types and address-geometry constants for the L2 cache
//             slice (FSM state encoding, cache-line type, address widths).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package l2_types_pkg;

    localparam int OFFSET_BITS = 4;
    localparam int ADDR_BITS   = 16;

    typedef logic [127:0] line_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } l2_state_e;

endpackage : l2_types_pkg
`default_nettype wire

// File: rtl/l2_cache_if.sv
`default_nettype none
// ============================================================================
//  Module   : l2_cache_if
//  Purpose  : Bundles the arbiter-side line request port (mem_*) and the
//             physical-memory port (pmem_*) of the L2 cache.
//  Ports    : modport slave  - the cache: accepts mem_* requests, issues pmem_*
//             modport master - the environment: arbiter plus physical memory
//  Revision : 1.0 - initial release
// ============================================================================
interface l2_cache_if;
    import l2_types_pkg::*;

    // Arbiter side
    logic                 mem_read;
    logic                 mem_write;
    logic [ADDR_BITS-1:0] mem_addr;
    line_t                mem_wdata;
    line_t                mem_rdata;
    logic                 mem_resp;

    // Physical memory side
    logic                 pmem_read;
    logic                 pmem_write;
    logic [ADDR_BITS-1:0] pmem_addr;
    line_t                pmem_wdata;
    line_t                pmem_rdata;
    logic                 pmem_resp;

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata, pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
    );

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata, pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
    );

endinterface : l2_cache_if
`default_nettype wire

// File: rtl/l2_cache_array.sv
`default_nettype none
// ============================================================================
//  Module   : l2_array
//  Purpose  : Tag / valid / dirty / data storage of the direct-mapped L2.
//             Combinational read of the line selected by i_idx; synchronous
//             write of each field under its own enable; valid and dirty
//             bits cleared synchronously while rst_n is low.
//  Ports    : clk, rst_n              clock, synchronous active-low reset
//             i_idx                   line index for both read and write
//             i_we_{data,tag,valid,dirty} per-field write enables
//             i_data, i_tag, i_valid, i_dirty  write values
//             o_data, o_tag, o_valid, o_dirty  contents of line i_idx
//  Revision : 1.0 - initial release
// ============================================================================
module l2_array
    import l2_types_pkg::*;
#(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = ADDR_BITS - OFFSET_BITS - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] i_idx,
    input  logic                  i_we_data,
    input  logic                  i_we_tag,
    input  logic                  i_we_valid,
    input  logic                  i_we_dirty,
    input  line_t                 i_data,
    input  logic [TAG_BITS-1:0]   i_tag,
    input  logic                  i_valid,
    input  logic                  i_dirty,
    output line_t                 o_data,
    output logic [TAG_BITS-1:0]   o_tag,
    output logic                  o_valid,
    output logic                  o_dirty
);
    localparam int LINES = 1 << INDEX_BITS;

    line_t               r_data  [LINES];
    logic [TAG_BITS-1:0] r_tag   [LINES];
    logic [LINES-1:0]    r_valid;
    logic [LINES-1:0]    r_dirty;

    // Status bits carry the reset; data and tag are qualified by valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (i_we_valid) r_valid[i_idx] <= i_valid;
            if (i_we_dirty) r_dirty[i_idx] <= i_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (i_we_data) r_data[i_idx] <= i_data;
        if (i_we_tag)  r_tag[i_idx]  <= i_tag;
    end

    assign o_data  = r_data[i_idx];
    assign o_tag   = r_tag[i_idx];
    assign o_valid = r_valid[i_idx];
    assign o_dirty = r_dirty[i_idx];

endmodule : l2_array
`default_nettype wire

// File: rtl/l2_cache.sv
`default_nettype none
// ============================================================================
//  Module   : l2_cache
//  Purpose  : Unified direct-mapped, write-back, write-allocate L2 cache.
//             Serves 128-bit line requests from the I/D arbiter and services
//             misses from physical memory. The missing line address is
//             captured when the miss is detected so WRITEBACK and FILL are
//             immune to the request changing or dropping mid-miss.
//  Ports    : clk    clock, rising edge
//             rst_n  synchronous reset, active low
//             bus    l2_cache_if.slave (mem_* request port, pmem_* port)
//  Revision : 1.0 - initial release
// ============================================================================
module l2_cache
    import l2_types_pkg::*;
#(
    parameter int INDEX_BITS = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    l2_cache_if.slave bus
);
    localparam int TAG_BITS  = ADDR_BITS - OFFSET_BITS - INDEX_BITS;
    localparam int LINE_BITS = ADDR_BITS - OFFSET_BITS;

    l2_state_e             r_state;
    l2_state_e             w_next_state;
    logic [LINE_BITS-1:0]  r_miss_addr;
    logic                  w_latch_miss;

    logic [INDEX_BITS-1:0] w_live_idx;
    logic [INDEX_BITS-1:0] w_miss_idx;
    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0]   w_live_tag;
    logic [TAG_BITS-1:0]   w_miss_tag;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_valid;
    logic                  w_dirty;
    line_t                 w_data;
    logic                  w_req;
    logic                  w_hit;
    logic                  w_unused_offset;

    logic                  w_we_data;
    logic                  w_we_tag;
    logic                  w_we_valid;
    logic                  w_we_dirty;
    logic                  w_set_valid;
    logic                  w_set_dirty;
    line_t                 w_wr_data;

    logic                  w_mem_resp;
    line_t                 w_mem_rdata;
    logic                  w_pmem_read;
    logic                  w_pmem_write;
    logic [ADDR_BITS-1:0]  w_pmem_addr;
    line_t                 w_pmem_wdata;

    assign w_live_idx      = bus.mem_addr[OFFSET_BITS +: INDEX_BITS];
    assign w_live_tag      = bus.mem_addr[ADDR_BITS-1 -: TAG_BITS];
    assign w_miss_idx      = r_miss_addr[INDEX_BITS-1:0];
    assign w_miss_tag      = r_miss_addr[LINE_BITS-1 -: TAG_BITS];
    // Byte offset within the line plays no part in a line-granular cache.
    assign w_unused_offset = ^bus.mem_addr[OFFSET_BITS-1:0];

    // Only IDLE looks at the live address; the miss states must stay on the
    // captured line regardless of what the arbiter presents meanwhile.
    assign w_idx = (r_state == IDLE) ? w_live_idx : w_miss_idx;
    assign w_req = bus.mem_read | bus.mem_write;
    assign w_hit = w_valid && (w_tag == w_live_tag);

    l2_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_idx      (w_idx),
        .i_we_data  (w_we_data),
        .i_we_tag   (w_we_tag),
        .i_we_valid (w_we_valid),
        .i_we_dirty (w_we_dirty),
        .i_data     (w_wr_data),
        .i_tag      (w_miss_tag),
        .i_valid    (w_set_valid),
        .i_dirty    (w_set_dirty),
        .o_data     (w_data),
        .o_tag      (w_tag),
        .o_valid    (w_valid),
        .o_dirty    (w_dirty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_miss_addr <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_latch_miss) begin
                r_miss_addr <= bus.mem_addr[ADDR_BITS-1:OFFSET_BITS];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_latch_miss = 1'b0;
        w_we_data    = 1'b0;
        w_we_tag     = 1'b0;
        w_we_valid   = 1'b0;
        w_we_dirty   = 1'b0;
        w_set_valid  = 1'b0;
        w_set_dirty  = 1'b0;
        w_wr_data    = bus.mem_wdata;
        w_mem_resp   = 1'b0;
        w_mem_rdata  = '0;
        w_pmem_read  = 1'b0;
        w_pmem_write = 1'b0;
        w_pmem_addr  = '0;
        w_pmem_wdata = '0;

        // Everything is quiet while reset is held, even if the state
        // register has not yet been returned to IDLE.
        if (rst_n) begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        if (w_hit) begin
                            w_mem_resp = 1'b1;
                            // Simultaneous read+write is a write.
                            if (bus.mem_write) begin
                                w_we_data   = 1'b1;
                                w_we_dirty  = 1'b1;
                                w_set_dirty = 1'b1;
                            end else begin
                                w_mem_rdata = w_data;
                            end
                        end else begin
                            w_latch_miss = 1'b1;
                            w_next_state = (w_valid && w_dirty) ? WRITEBACK : FILL;
                        end
                    end
                end

                WRITEBACK: begin
                    w_pmem_write = 1'b1;
                    w_pmem_addr  = {w_tag, w_miss_idx, {OFFSET_BITS{1'b0}}};
                    w_pmem_wdata = w_data;
                    if (bus.pmem_resp) begin
                        w_we_dirty   = 1'b1;
                        w_set_dirty  = 1'b0;
                        w_next_state = FILL;
                    end
                end

                FILL: begin
                    w_pmem_read = 1'b1;
                    w_pmem_addr = {r_miss_addr, {OFFSET_BITS{1'b0}}};
                    if (bus.pmem_resp) begin
                        w_wr_data    = bus.pmem_rdata;
                        w_we_data    = 1'b1;
                        w_we_tag     = 1'b1;
                        w_we_valid   = 1'b1;
                        w_set_valid  = 1'b1;
                        w_we_dirty   = 1'b1;
                        w_set_dirty  = 1'b0;
                        w_next_state = IDLE;
                    end
                end

                default: w_next_state = IDLE;
            endcase
        end
    end

    assign bus.mem_resp   = w_mem_resp;
    assign bus.mem_rdata  = w_mem_rdata;
    assign bus.pmem_read  = w_pmem_read;
    assign bus.pmem_write = w_pmem_write;
    assign bus.pmem_addr  = w_pmem_addr;
    assign bus.pmem_wdata = w_pmem_wdata;

endmodule : l2_cache
`default_nettype wire

// File: tb/tb_l2_cache.sv
`default_nettype none
// ============================================================================
//  Module   : tb_l2_cache
//  Purpose  : Self-checking bench for l2_cache. Expected pmem transactions
//             and expected read data are queued as stimulus is issued and
//             popped as the cache produces them.
//  Ports    : none (top-level bench)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_l2_cache;
    import l2_types_pkg::*;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        line_t       data;
    } pm_exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    pm_exp_t pm_q[$];
    line_t   rd_q[$];
    line_t   pmem_mem [logic [15:0]];

    l2_cache_if bus();

    l2_cache #(.INDEX_BITS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Backing memory: untouched lines hold an address-derived pattern.
    function automatic line_t pm_read(input logic [15:0] a);
        line_t v;
        if (pmem_mem.exists(a)) return pmem_mem[a];
        for (int i = 0; i < 8; i++) v[i*16 +: 16] = a + 16'(i) * 16'h0101;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pm(input bit wr, input logic [15:0] a, input line_t d);
        pm_exp_t e;
        e.wr = wr; e.addr = a; e.data = d;
        pm_q.push_back(e);
    endtask

    // Issue one request and service pmem until mem_resp. Entered and left
    // 1 time unit after a rising edge.
    task automatic do_req(input logic rd, input logic wr, input logic [15:0] addr,
                          input line_t wd, input bit sw_en, input logic [15:0] sw_addr,
                          input string nm);
        bit          done      = 0;
        int          pm_wait   = 0;
        int          pulse_cyc = -10;
        logic [15:0] pm_seen   = '0;
        pm_exp_t     e;
        line_t       er;
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.mem_addr  = addr;
        bus.mem_wdata = wd;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            #1;
            if (bus.mem_resp) begin
                done = 1;
                if (rd && !wr) begin
                    checks++;
                    if (rd_q.size() == 0) begin
                        failures++;
                        $display("FAIL %s rdata: got %h, required no response", nm, bus.mem_rdata);
                    end else begin
                        er = rd_q.pop_front();
                        if (bus.mem_rdata !== er) begin
                            failures++;
                            $display("FAIL %s rdata: got %h, required %h", nm, bus.mem_rdata, er);
                        end
                    end
                end
                if (pulse_cyc >= 0) begin
                    checks++;
                    if (cyc - pulse_cyc != 1) begin
                        failures++;
                        $display("FAIL %s latency: got %0d cycles after fill, required 1", nm, cyc - pulse_cyc);
                    end
                end
            end else if (bus.pmem_read || bus.pmem_write) begin
                checks++;
                if (pm_wait == 0) begin
                    if (bus.pmem_read && bus.pmem_write) begin
                        failures++;
                        $display("FAIL %s pmem_excl: got read=1 write=1, required one", nm);
                    end else if (pm_q.size() == 0) begin
                        failures++;
                        $display("FAIL %s pmem_unexpected: got wr=%0b addr=%h, required none", nm, bus.pmem_write, bus.pmem_addr);
                    end else begin
                        e = pm_q.pop_front();
                        if (bus.pmem_write !== e.wr || bus.pmem_addr !== e.addr ||
                            (e.wr && bus.pmem_wdata !== e.data)) begin
                            failures++;
                            $display("FAIL %s pmem_txn: got wr=%0b addr=%h wdata=%h, required wr=%0b addr=%h wdata=%h",
                                     nm, bus.pmem_write, bus.pmem_addr, bus.pmem_wdata, e.wr, e.addr, e.data);
                        end
                    end
                    pm_seen = bus.pmem_addr;
                    if (sw_en) begin
                        bus.mem_addr = sw_addr;
                        sw_en = 0;
                    end
                end else if (bus.pmem_addr !== pm_seen) begin
                    failures++;
                    $display("FAIL %s pmem_stable: got addr=%h, required %h", nm, bus.pmem_addr, pm_seen);
                end
                pm_wait++;
                if (pm_wait == 3) begin
                    if (bus.pmem_write) pmem_mem[bus.pmem_addr] = bus.pmem_wdata;
                    else                bus.pmem_rdata = pm_read(bus.pmem_addr);
                    bus.pmem_resp = 1'b1;
                    pulse_cyc     = cyc;
                    pm_wait       = 0;
                end
            end
            tick();
            bus.pmem_resp = 1'b0;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s timeout: got no mem_resp in 200 cycles, required mem_resp", nm);
        end
        checks++;
        if (pm_q.size() != 0) begin
            failures++;
            $display("FAIL %s pmem_missing: got %0d expected txns unissued, required 0", nm, pm_q.size());
            pm_q.delete();
        end
        rd_q.delete();
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.mem_read   = 1'b1;
        bus.mem_write  = 1'b0;
        bus.mem_addr   = 16'h1230;
        bus.mem_wdata  = '0;
        bus.pmem_rdata = '0;
        bus.pmem_resp  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (bus.mem_resp !== 1'b0 || bus.mem_rdata !== '0) begin
            failures++;
            $display("FAIL reset_mem: got resp=%b rdata=%h, required 0/0", bus.mem_resp, bus.mem_rdata);
        end
        checks++;
        if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0 || bus.pmem_addr !== '0 || bus.pmem_wdata !== '0) begin
            failures++;
            $display("FAIL reset_pmem: got rd=%b wr=%b addr=%h, required all 0", bus.pmem_read, bus.pmem_write, bus.pmem_addr);
        end
        rst_n        = 1'b1;
        bus.mem_read = 1'b0;
        tick();
        #1;
        checks++;
        if (bus.mem_resp !== 1'b0 || bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0 || bus.pmem_addr !== '0) begin
            failures++;
            $display("FAIL idle_quiet: got resp=%b rd=%b wr=%b addr=%h, required all 0",
                     bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.pmem_addr);
        end
        tick();
    endtask

    task automatic test_cold_read();
        push_pm(0, 16'h1230, '0);
        rd_q.push_back(pm_read(16'h1230));
        do_req(1, 0, 16'h1230, '0, 0, '0, "cold_read");
    endtask

    task automatic test_write_hit(input line_t y);
        do_req(0, 1, 16'h1230, y, 0, '0, "write_hit");
        rd_q.push_back(y);
        do_req(1, 0, 16'h1230, '0, 0, '0, "read_after_write");
    endtask

    task automatic test_conflict(input line_t y);
        push_pm(1, 16'h1230, y);
        push_pm(0, 16'h5230, '0);
        rd_q.push_back(pm_read(16'h5230));
        do_req(1, 0, 16'h5230, '0, 0, '0, "conflict_read");
        rd_q.push_back(pm_read(16'h5230));
        do_req(1, 0, 16'h5230, '0, 0, '0, "conflict_rehit");
    endtask

    task automatic test_addr_switch();
        push_pm(0, 16'h9230, '0);
        rd_q.push_back(pm_read(16'h9230));
        do_req(1, 0, 16'h9230, '0, 0, '0, "evict_clean");
        push_pm(0, 16'h5230, '0);
        push_pm(0, 16'h0040, '0);
        rd_q.push_back(pm_read(16'h0040));
        do_req(1, 0, 16'h5230, '0, 1, 16'h0040, "addr_switch");
        rd_q.push_back(pm_read(16'h5230));
        do_req(1, 0, 16'h5230, '0, 0, '0, "switch_installed");
    endtask

    task automatic test_rw_both(input line_t w);
        push_pm(0, 16'h2350, '0);
        do_req(1, 1, 16'h2350, w, 0, '0, "rw_both_miss");
        rd_q.push_back(w);
        do_req(1, 0, 16'h2350, '0, 0, '0, "rw_both_line");
        push_pm(1, 16'h2350, w);
        push_pm(0, 16'h6350, '0);
        rd_q.push_back(pm_read(16'h6350));
        do_req(1, 0, 16'h6350, '0, 0, '0, "rw_both_dirty");
    endtask

    task automatic test_back_to_back();
        // A stray pmem_resp in IDLE must not touch any line.
        bus.pmem_rdata = '1;
        bus.pmem_resp  = 1'b1;
        tick();
        bus.pmem_resp  = 1'b0;
        rd_q.push_back(pm_read(16'h5230));
        do_req(1, 0, 16'h523F, '0, 0, '0, "b2b_idx3");
        rd_q.push_back(pm_read(16'h0040));
        do_req(1, 0, 16'h0047, '0, 0, '0, "b2b_idx4");
        rd_q.push_back(pm_read(16'h6350));
        do_req(1, 0, 16'h635A, '0, 0, '0, "b2b_idx5");
    endtask

    task automatic test_reset_mid_wb(input line_t z);
        do_req(0, 1, 16'h5230, z, 0, '0, "dirty_setup");
        bus.mem_read = 1'b1;
        bus.mem_addr = 16'h1230;
        tick();
        #1;
        checks++;
        if (bus.pmem_write !== 1'b1 || bus.pmem_addr !== 16'h5230 || bus.pmem_wdata !== z) begin
            failures++;
            $display("FAIL wb_start: got wr=%b addr=%h wdata=%h, required 1/5230/%h",
                     bus.pmem_write, bus.pmem_addr, bus.pmem_wdata, z);
        end
        rst_n = 1'b0;
        tick();
        #1;
        checks++;
        if (bus.pmem_write !== 1'b0 || bus.pmem_read !== 1'b0 || bus.mem_resp !== 1'b0) begin
            failures++;
            $display("FAIL wb_reset: got wr=%b rd=%b resp=%b, required 0/0/0", bus.pmem_write, bus.pmem_read, bus.mem_resp);
        end
        rst_n        = 1'b1;
        bus.mem_read = 1'b0;
        tick();
        #1;
        checks++;
        if (bus.pmem_write !== 1'b0 || bus.pmem_read !== 1'b0) begin
            failures++;
            $display("FAIL wb_abort_idle: got wr=%b rd=%b, required 0/0", bus.pmem_write, bus.pmem_read);
        end
        tick();
        push_pm(0, 16'h1230, '0);
        rd_q.push_back(pm_read(16'h1230));
        do_req(1, 0, 16'h1230, '0, 0, '0, "post_reset_miss");
        push_pm(0, 16'h5230, '0);
        rd_q.push_back(pm_read(16'h5230));
        do_req(1, 0, 16'h5230, '0, 0, '0, "dirty_lost");
    endtask

    initial begin
        line_t y, z, w;
        y = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
        z = {4{32'h5A5AA5A5}};
        w = {32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888};
        test_reset();
        test_cold_read();
        test_write_hit(y);
        test_conflict(y);
        test_addr_switch();
        test_rw_both(w);
        test_back_to_back();
        test_reset_mid_wb(z);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_l2_cache
`default_nettype wire
